// File: rtl/opl_pkg.sv
// Shared definitions for the OPL input scheduler: FSM encoding and counter width.
package opl_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/rr_select.sv
// Wrapping priority scan: picks the first requester after ptr, modulo NUM_PORTS.
module rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic                 found
);

  logic [PTR_W-1:0] w_idx;

  // ptr itself is scanned last, so the previous owner has lowest priority
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    w_idx  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[w_idx]) begin
        onehot[w_idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/opl_input_scheduler.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream inputs into one output,
// with per-port forwarded-packet counters.
module opl_input_scheduler
  import opl_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_resetn,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  input  logic                                      cnt_clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]            pkt_count,
  output logic [NUM_PORTS-1:0]                      grant
);

  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int SW    = C_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int PTR_W = $clog2(NUM_PORTS);

  state_t                       r_state, w_stateNext;
  logic [NUM_PORTS-1:0]         r_grant, w_grantNext;
  logic [PTR_W-1:0]             r_rrPtr, w_rrPtrNext;
  logic [NUM_PORTS*CNT_WIDTH-1:0] r_pktCount, w_pktCountNext;
  logic [PTR_W-1:0]             w_ownerIdx;
  logic [NUM_PORTS-1:0]         w_selOneHot;
  logic                         w_selFound;
  logic                         w_lastBeat;

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_select (
    .req    (s_axis_tvalid),
    .ptr    (r_rrPtr),
    .onehot (w_selOneHot),
    .found  (w_selFound)
  );

  always_comb begin
    w_ownerIdx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) w_ownerIdx = PTR_W'(i);
    end
  end

  // Grant is all-zero in IDLE, so the mux naturally yields a silent output there
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_state == IN_PACKET && r_grant[i]) begin
        m_axis_tdata  = s_axis_tdata[i*DW +: DW];
        m_axis_tstrb  = s_axis_tstrb[i*SW +: SW];
        m_axis_tuser  = s_axis_tuser[i*UW +: UW];
        m_axis_tvalid = s_axis_tvalid[i];
        m_axis_tlast  = s_axis_tlast[i];
      end
    end
    s_axis_tready = (r_state == IN_PACKET && m_axis_tready) ? r_grant : '0;
  end

  assign w_lastBeat = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    w_stateNext = r_state;
    w_grantNext = r_grant;
    w_rrPtrNext = r_rrPtr;
    case (r_state)
      IDLE: begin
        if (w_selFound) begin
          w_stateNext = IN_PACKET;
          w_grantNext = w_selOneHot;
        end
      end
      IN_PACKET: begin
        if (w_lastBeat) begin
          w_stateNext = IDLE;
          w_grantNext = '0;
          w_rrPtrNext = w_ownerIdx;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_grantNext = '0;
      end
    endcase
  end

  // Clear takes priority over a coincident packet completion
  always_comb begin
    w_pktCountNext = r_pktCount;
    if (cnt_clear) begin
      w_pktCountNext = '0;
    end else if (w_lastBeat) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_grant[i]) begin
          w_pktCountNext[i*CNT_WIDTH +: CNT_WIDTH] =
            r_pktCount[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rrPtr    <= PTR_W'(NUM_PORTS - 1);
      r_pktCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_grant    <= w_grantNext;
      r_rrPtr    <= w_rrPtrNext;
      r_pktCount <= w_pktCountNext;
    end
  end

  assign grant     = r_grant;
  assign pkt_count = r_pktCount;

endmodule

// File: tb/tb_opl_input_scheduler.sv
// Self-checking bench for opl_input_scheduler: packet-level reference model plus directed scenarios.
module tb_opl_input_scheduler;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int SW = DW / 8;

  logic               clk = 1'b0;
  logic               rstN;
  logic [NP*DW-1:0]   sTdata;
  logic [NP*SW-1:0]   sTstrb;
  logic [NP*UW-1:0]   sTuser;
  logic [NP-1:0]      sTvalid;
  logic [NP-1:0]      sTlast;
  logic [NP-1:0]      sTready;
  logic [DW-1:0]      mTdata;
  logic [SW-1:0]      mTstrb;
  logic [UW-1:0]      mTuser;
  logic               mTvalid;
  logic               mTlast;
  logic               mTready;
  logic               cntClear;
  logic [NP*32-1:0]   pktCount;
  logic [NP-1:0]      grant;

  always #5 clk = ~clk;

  opl_input_scheduler #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS          (NP)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rstN),
    .s_axis_tdata  (sTdata),
    .s_axis_tstrb  (sTstrb),
    .s_axis_tuser  (sTuser),
    .s_axis_tvalid (sTvalid),
    .s_axis_tlast  (sTlast),
    .s_axis_tready (sTready),
    .m_axis_tdata  (mTdata),
    .m_axis_tstrb  (mTstrb),
    .m_axis_tuser  (mTuser),
    .m_axis_tvalid (mTvalid),
    .m_axis_tlast  (mTlast),
    .m_axis_tready (mTready),
    .cnt_clear     (cntClear),
    .pkt_count     (pktCount),
    .grant         (grant)
  );

  int checks = 0;
  int errors = 0;

  // Upstream packet sources, one per port
  int             srcLen [NP];
  int             srcSeq [NP];
  int             srcPkt [NP];
  bit             hold   [NP];
  logic [DW-1:0]  srcData[NP];
  logic [SW-1:0]  srcStrb[NP];
  logic [UW-1:0]  srcUser[NP];
  logic [NP-1:0]  accMask = '0;
  logic [DW-1:0]  rxQ[$];

  // Reference model: current owner (-1 = idle), last served port, packet counters
  int             mOwner;
  int             mRr;
  logic [31:0]    mCnt[NP];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic newBeat(input int p);
    logic [7:0]  pb;
    logic [7:0]  kb;
    logic [15:0] sq;
    int          pk;
    int          s;
    pk = srcPkt[p];
    s  = srcSeq[p];
    pb = p[7:0];
    kb = pk[7:0];
    sq = s[15:0];
    srcData[p] = {pb, kb, sq};
    srcStrb[p] = SW'($urandom);
    srcUser[p] = UW'($urandom);
  endtask

  task automatic loadPacket(input int p, input int len);
    srcPkt[p]++;
    srcLen[p] = len;
    srcSeq[p] = 0;
    newBeat(p);
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++) begin
      sTvalid[p]          = (srcLen[p] > 0) && !hold[p];
      sTlast[p]           = (srcLen[p] == 1);
      sTdata[p*DW +: DW]  = srcData[p];
      sTstrb[p*SW +: SW]  = srcStrb[p];
      sTuser[p*UW +: UW]  = srcUser[p];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (accMask[p]) begin
        srcLen[p]--;
        srcSeq[p]++;
        if (srcLen[p] > 0) newBeat(p);
      end
    end
    applyStimulus();
  endtask

  task automatic assertReset();
    rstN     = 1'b0;
    mOwner   = -1;
    mRr      = NP - 1;
    for (int p = 0; p < NP; p++) begin
      mCnt[p]   = '0;
      srcLen[p] = 0;
      hold[p]   = 1'b0;
    end
    cntClear = 1'b0;
    mTready  = 1'b1;
    applyStimulus();
  endtask

  task automatic applyReset();
    assertReset();
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
  endtask

  // Model advances on every rising edge using the inputs that were stable before it
  always @(posedge clk) begin
    bit found;
    int p;
    if (rstN) begin
      if (cntClear) begin
        for (int i = 0; i < NP; i++) mCnt[i] = '0;
      end else if (mOwner >= 0 && sTvalid[mOwner] && mTready && sTlast[mOwner]) begin
        mCnt[mOwner] = mCnt[mOwner] + 1;
      end
      if (mOwner < 0) begin
        found = 0;
        for (int i = 1; i <= NP; i++) begin
          p = (mRr + i) % NP;
          if (!found && sTvalid[p]) begin
            mOwner = p;
            found  = 1;
          end
        end
      end else if (sTvalid[mOwner] && mTready && sTlast[mOwner]) begin
        mRr    = mOwner;
        mOwner = -1;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [NP-1:0] expGrant;
    logic [NP-1:0] expReady;
    logic          expValid;
    accMask  = sTvalid & sTready;
    if (mTvalid && mTready) rxQ.push_back(mTdata);
    expGrant = (mOwner >= 0) ? NP'(1 << mOwner) : '0;
    expValid = (mOwner >= 0) ? sTvalid[mOwner] : 1'b0;
    expReady = (mOwner >= 0 && mTready) ? NP'(1 << mOwner) : '0;
    checkOutput("grant", grant, expGrant);
    checkOutput("m_tvalid", mTvalid, expValid);
    checkOutput("s_tready", sTready, expReady);
    checkOutput("pkt_count", pktCount, {mCnt[3], mCnt[2], mCnt[1], mCnt[0]});
    if (expValid) begin
      checkOutput("m_tdata", mTdata, sTdata[mOwner*DW +: DW]);
      checkOutput("m_tstrb", mTstrb, sTstrb[mOwner*SW +: SW]);
      checkOutput("m_tuser", mTuser, sTuser[mOwner*UW +: UW]);
      checkOutput("m_tlast", mTlast, sTlast[mOwner]);
    end
  end

  initial begin
    logic [NP-1:0]    expSeq[9];
    logic [NP*32-1:0] preload;
    logic [DW-1:0]    e;
    logic [7:0]       pb;
    int               n;
    int               pk;

    for (int p = 0; p < NP; p++) begin
      srcPkt[p] = 0;
      srcLen[p] = 0;
      srcSeq[p] = 0;
      hold[p]   = 1'b0;
      newBeat(p);
    end
    sTvalid = '0;
    sTlast  = '0;

    // Test 1: two 3-beat packets on ports 0 and 2
    applyReset();
    checkOutput("t1_reset_count", pktCount, '0);
    loadPacket(0, 3);
    loadPacket(2, 3);
    applyStimulus();
    repeat (7) step();
    checkOutput("t1_count_mid", pktCount, {32'd0, 32'd0, 32'd0, 32'd1});
    step();
    checkOutput("t1_count_end", pktCount, {32'd0, 32'd1, 32'd0, 32'd1});

    // Test 2: all ports continuously offering single-beat packets
    applyReset();
    expSeq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int p = 0; p < NP; p++) loadPacket(p, 1);
    applyStimulus();
    for (int i = 0; i < 9; i++) begin
      step();
      for (int p = 0; p < NP; p++) if (srcLen[p] == 0) loadPacket(p, 1);
      applyStimulus();
      checkOutput("t2_grant_order", grant, expSeq[i]);
    end

    // Test 3: downstream backpressure toggling during a 4-beat packet
    applyReset();
    rxQ.delete();
    loadPacket(1, 4);
    applyStimulus();
    for (int i = 0; i < 12; i++) begin
      mTready = (i % 2 == 0);
      applyStimulus();
      step();
    end
    mTready = 1'b1;
    checkOutput("t3_beats", rxQ.size(), 4);
    pk = srcPkt[1];
    pb = pk[7:0];
    for (int k = 0; k < 4 && k < rxQ.size(); k++) begin
      e = {8'd1, pb, k[15:0]};
      checkOutput("t3_beat_data", rxQ[k], e);
    end
    checkOutput("t3_count", pktCount, {32'd0, 32'd0, 32'd1, 32'd0});

    // Test 4: owner stalls mid-packet while another port waits
    applyReset();
    loadPacket(3, 4);
    applyStimulus();
    step();
    step();
    hold[3] = 1'b1;
    loadPacket(0, 1);
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("t4_grant_held", grant, 4'b1000);
    end
    hold[3] = 1'b0;
    applyStimulus();
    n = 0;
    while (n < 20 && pktCount[127:96] == 32'd0) begin
      step();
      n++;
    end
    checkOutput("t4_tlast_timeout", (n < 20), 1'b1);
    step();
    checkOutput("t4_next_grant", grant, 4'b0001);

    // Test 5: counter wrap and clear-versus-increment priority
    applyReset();
    preload = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    force dut.r_pktCount = preload;
    mCnt[0] = 32'hFFFF_FFFF;
    #1 release dut.r_pktCount;
    #1 checkOutput("t5_preload", pktCount, preload);
    loadPacket(0, 1);
    applyStimulus();
    repeat (3) step();
    checkOutput("t5_wrap", pktCount[31:0], 32'd0);
    loadPacket(0, 1);
    applyStimulus();
    step();
    cntClear = 1'b1;
    step();
    cntClear = 1'b0;
    checkOutput("t5_clear_wins", pktCount, '0);

    // Test 6: reset in the middle of a 5-beat packet
    applyReset();
    loadPacket(2, 5);
    applyStimulus();
    repeat (3) step();
    #2;
    assertReset();
    #1;
    checkOutput("t6_rst_tvalid", mTvalid, 1'b0);
    checkOutput("t6_rst_tready", sTready, '0);
    checkOutput("t6_rst_grant", grant, '0);
    loadPacket(2, 2);
    loadPacket(0, 2);
    applyStimulus();
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    step();
    checkOutput("t6_restart_port0", grant, 4'b0001);

    // Randomised traffic with backpressure, stalls and clears
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      mTready  = ($urandom_range(3) != 0);
      cntClear = ($urandom_range(63) == 0);
      for (int p = 0; p < NP; p++) begin
        if (srcLen[p] == 0 && $urandom_range(3) == 0) loadPacket(p, $urandom_range(1, 6));
        hold[p] = ($urandom_range(7) == 0);
      end
      applyStimulus();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
